// File: rtl/emergency_preempt_conditioner_pkg.sv
// Shared definitions for the emergency preemption conditioner: FSM encoding
// and default timing constants.
package emergency_preempt_conditioner_pkg;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACTIVE   = 2'b01,
    COOLDOWN = 2'b10
  } preempt_state_t;

  localparam int unsigned DefDebounceCyc = 4;
  localparam int unsigned DefMinActive   = 8;
  localparam int unsigned DefMaxActive   = 40;
  localparam int unsigned DefCooldownCyc = 12;
  localparam int unsigned DefCntW        = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer. The debounced
// output flips only after DEBOUNCE_CYC consecutive synchronised samples that
// disagree with it. Reusable for pedestrian buttons and similar inputs.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q_deb
);

  localparam int unsigned DcntW = $clog2(DEBOUNCE_CYC + 1);

  logic             meta_q;
  logic             sync_q;
  logic             deb_q;
  logic [DcntW-1:0] dcnt_q;

  // Synchroniser plus debounce counter; reset clears everything to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
      if (sync_q != deb_q) begin
        if (dcnt_q == DcntW'(DEBOUNCE_CYC - 1)) begin
          deb_q  <= sync_q;
          dcnt_q <= '0;
        end else begin
          dcnt_q <= dcnt_q + 1'b1;
        end
      end else begin
        dcnt_q <= '0;
      end
    end
  end

  assign q_deb = deb_q;

endmodule

// File: rtl/emergency_preempt_conditioner.sv
// Conditions a raw emergency-vehicle detector into a bounded preemption
// request: minimum and maximum on-time, enforced cooldown, a sticky timeout
// flag and a saturating preemption counter.
module emergency_preempt_conditioner
  import emergency_preempt_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
  parameter int unsigned MIN_ACTIVE   = DefMinActive,
  parameter int unsigned MAX_ACTIVE   = DefMaxActive,
  parameter int unsigned COOLDOWN_CYC = DefCooldownCyc,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             det_raw,
  input  logic             clr_flags,
  output logic             emergency,
  output logic             cooldown,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] preempt_count,
  output logic [1:0]       state_o
);

  localparam int unsigned TimerMax = (MAX_ACTIVE > COOLDOWN_CYC) ? MAX_ACTIVE : COOLDOWN_CYC;
  localparam int unsigned TimerW   = $clog2(TimerMax);

  logic deb;

  preempt_state_t    state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              armed_q, armed_d;
  logic              tflag_q, tflag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  sync_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sync_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (det_raw),
    .q_deb   (deb)
  );

  // State register; armed resets to 1 so the first detection is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      armed_q <= 1'b1;
      tflag_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      armed_q <= armed_d;
      tflag_q <= tflag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; set/increment are applied after clr_flags so they win.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    armed_d = armed_q;
    tflag_d = tflag_q;
    cnt_d   = cnt_q;

    if (clr_flags) begin
      tflag_d = 1'b0;
      cnt_d   = '0;
    end

    if (!en) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          timer_d = '0;
          if (deb && armed_q) begin
            state_d = ACTIVE;
            if (clr_flags) begin
              cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (!deb) begin
            armed_d = 1'b1;
          end
        end
        ACTIVE: begin
          if (timer_q == TimerW'(MAX_ACTIVE - 1)) begin
            // Stuck detector: cut off and require deb low before re-arming.
            state_d = COOLDOWN;
            timer_d = '0;
            tflag_d = 1'b1;
            armed_d = 1'b0;
          end else if (!deb && (timer_q >= TimerW'(MIN_ACTIVE - 1))) begin
            state_d = COOLDOWN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        COOLDOWN: begin
          if (timer_q == TimerW'(COOLDOWN_CYC - 1)) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    emergency = (state_q == ACTIVE);
    cooldown  = (state_q == COOLDOWN);
  end

  assign timeout_flag  = tflag_q;
  assign preempt_count = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_emergency_preempt_conditioner.sv
// Scoreboard bench: stimulus pushes expected output snapshots tagged with the
// cycle they apply to; a monitor on the falling edge pops and compares.
module tb_emergency_preempt_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       det_raw;
  logic       clr_flags;
  logic       emergency;
  logic       cooldown;
  logic       timeout_flag;
  logic [7:0] preempt_count;
  logic [1:0] state_o;

  typedef struct {
    int         cyc;
    string      name;
    logic       emg;
    logic       cd;
    logic       tf;
    logic [7:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  emergency_preempt_conditioner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .det_raw       (det_raw),
    .clr_flags     (clr_flags),
    .emergency     (emergency),
    .cooldown      (cooldown),
    .timeout_flag  (timeout_flag),
    .preempt_count (preempt_count),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic emg, input logic cd, input logic tf,
                            input logic [7:0] cnt, input logic [1:0] st);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.emg  = emg;
    e.cd   = cd;
    e.tf   = tf;
    e.cnt  = cnt;
    e.st   = st;
    sb.push_back(e);
  endtask

  // Monitor: compare every snapshot due at or before this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || emergency !== e.emg || cooldown !== e.cd || timeout_flag !== e.tf ||
          preempt_count !== e.cnt || state_o !== e.st) begin
        errors++;
        $display("FAIL %s @cyc %0d: got emg=%b cd=%b tf=%b cnt=%0d st=%b, want emg=%b cd=%b tf=%b cnt=%0d st=%b",
                 e.name, cyc, emergency, cooldown, timeout_flag, preempt_count, state_o,
                 e.emg, e.cd, e.tf, e.cnt, e.st);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; det_raw = 1'b0; clr_flags = 1'b0;
    tick(2);
    expect_now("reset", 0, 0, 0, 8'd0, 2'b00);
    rst_n = 1'b1;
    tick(2);

    // Qualified detection, short hold: exact latency, 8-cycle min pulse, 12-cycle cooldown.
    det_raw = 1'b1;
    tick(6);  expect_now("lat_edge6", 0, 0, 0, 8'd1 - 8'd1, 2'b00);
    tick(1);  expect_now("lat_edge7", 1, 0, 0, 8'd1, 2'b01);
    tick(1);  det_raw = 1'b0;
    tick(6);  expect_now("min_last_active", 1, 0, 0, 8'd1, 2'b01);
    tick(1);  expect_now("min_end", 0, 1, 0, 8'd1, 2'b10);
    tick(11); expect_now("cd_last", 0, 1, 0, 8'd1, 2'b10);
    tick(1);  expect_now("cd_end", 0, 0, 0, 8'd1, 2'b00);
    tick(2);

    // Glitch of 3 cycles is rejected.
    det_raw = 1'b1;
    tick(3);
    det_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      expect_now("glitch", 0, 0, 0, 8'd1, 2'b00);
    end

    // Stuck detector: exactly 40 cycles then timeout, no retrigger while held.
    det_raw = 1'b1;
    tick(7);  expect_now("stuck_rise", 1, 0, 0, 8'd2, 2'b01);
    tick(39); expect_now("stuck_last", 1, 0, 0, 8'd2, 2'b01);
    tick(1);  expect_now("timeout", 0, 1, 1, 8'd2, 2'b10);
    tick(12); expect_now("stuck_idle", 0, 0, 1, 8'd2, 2'b00);
    tick(20); expect_now("no_retrigger", 0, 0, 1, 8'd2, 2'b00);
    clr_flags = 1'b1;
    tick(1);  clr_flags = 1'b0;
    expect_now("clr_flags", 0, 0, 0, 8'd0, 2'b00);
    det_raw = 1'b0;
    tick(10);
    det_raw = 1'b1;
    tick(7);  expect_now("rearm_rise", 1, 0, 0, 8'd1, 2'b01);

    // en=0 mid-ACTIVE forces IDLE; armed held so it re-enters at once.
    tick(3);
    en = 1'b0;
    tick(1);  expect_now("en_off", 0, 0, 0, 8'd1, 2'b00);
    en = 1'b1;
    tick(1);  expect_now("en_on", 1, 0, 0, 8'd2, 2'b01);

    // Reset mid-ACTIVE: everything clears, no cooldown.
    tick(2);
    rst_n = 1'b0;
    tick(1);  expect_now("rst_mid", 0, 0, 0, 8'd0, 2'b00);
    rst_n = 1'b1;
    tick(1);  expect_now("rst_no_cd", 0, 0, 0, 8'd0, 2'b00);

    // clr_flags coincident with timeout: flag set wins, count clears.
    tick(6);  expect_now("post_rst_rise", 1, 0, 0, 8'd1, 2'b01);
    tick(39);
    clr_flags = 1'b1;
    tick(1);  clr_flags = 1'b0;
    expect_now("clr_vs_timeout", 0, 1, 1, 8'd0, 2'b10);
    tick(12); expect_now("clr_idle", 0, 0, 1, 8'd0, 2'b00);

    // clr_flags coincident with count increment: count reads 1.
    det_raw = 1'b0;
    tick(10);
    det_raw = 1'b1;
    tick(6);  expect_now("pre_inc", 0, 0, 1, 8'd0, 2'b00);
    clr_flags = 1'b1;
    tick(1);  clr_flags = 1'b0;
    expect_now("clr_vs_inc", 1, 0, 0, 8'd1, 2'b01);

    tick(2);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
